video_serialiser_pal: RTL
=========================

Name: video_serialiser_pal

Overview:
- Parametrised successor of the current video ULA: pixel serialiser, palette lookup, flash and cursor overlay.
- All logic runs in the single PIXELCLK domain. Derived clocks are replaced by one-cycle clock-enable strobes (CE_RAM, CE_PROC, CE_CRTC).
- Adds three things the current block lacks: configurable channel depth, configurable palette size and cursor length, and a synchronous write port with a pixel-format register.
- Sits between video RAM/CRTC and the DAC/VGA output.

Parameters:
CH_BITS, 1, bits per colour channel; each of RED/GREEN/BLUE is CH_BITS wide.
IDX_BITS, 4, palette index width; the palette has 2**IDX_BITS entries (legal values 1..4).
CURSOR_SEGS, 3, cursor trail length in CRTC characters after the CURSOR pulse (legal values 1..8).

Ports:
PIXELCLK  in  1  pixel clock, the only clock.
RESET  in  1  asynchronous, active-high reset.
CTRL_WE  in  1  writes CTRL_DATA into CTRL.
CTRL_DATA  in  8  [7:5] cursor segment enables, [4] CRTC fast, [3:2] shift rate, [1] unused, [0] flash phase.
FMT_WE  in  1  writes FMT_DATA into FMT.
FMT_DATA  in  2  pixel index format.
PAL_WE  in  1  palette write strobe.
PAL_IDX  in  IDX_BITS  palette entry to write.
PAL_DATA  in  3*CH_BITS+1  {flash bit, B, G, R}.
DATA  in  8  video byte from RAM.
DISEN  in  1  display enable from the CRTC.
CURSOR  in  1  cursor strobe from the CRTC.
CE_RAM  out  1  strobe, one PIXELCLK in every 4.
CE_PROC  out  1  strobe, one PIXELCLK in every 8.
CE_CRTC  out  1  CE_PROC if CTRL[4]=1, otherwise a strobe one PIXELCLK in every 16.
RED  out  CH_BITS  pixel red.
GREEN  out  CH_BITS  pixel green.
BLUE  out  CH_BITS  pixel blue.

Behaviour:
- Reset, asynchronous: 4-bit DIV=0, CTRL=0, FMT=0, SHIFT=0, all palette entries=0, cursor segments=0, CUR_Q=0, DISEN_Q=0, RGB=0.
- Strobes after reset deassert: CE_RAM=0, CE_PROC=0, CE_CRTC=0.
- DIV: increments every PIXELCLK and wraps 15->0.
  - CE_RAM = (DIV[1:0]==3).
  - CE_PROC = (DIV[2:0]==7).
  - 16-cycle strobe = (DIV==15).
  - The strobes are combinational from DIV. First CE_PROC occurs 8 clocks after reset release.
- Register writes: take effect on the PIXELCLK edge where the strobe is high. New values are visible the next cycle.
  - CTRL_WE, FMT_WE and PAL_WE may all be high together; they are independent.
  - A palette write and a read of the same entry in one cycle returns the old value.
- Shift register SHIFT[7:0]:
  - If CE_CRTC: SHIFT<=DATA, DISEN_Q<=DISEN.
  - Else if shift tick: shift left by the FMT step and fill with 1s.
  - Load has priority over shift when both occur in the same cycle.
  - Shift tick = (DIV[2:0] & M)==M, with M=7/3/1/0 for CTRL[3:2]=00/01/10/11.
- FMT selects the index bits and the shift step:
  - 00: legacy interleaved {S7,S5,S3,S1}, step 1.
  - 01: 1bpp {S7}, step 1.
  - 10: 2bpp {S7,S6}, step 2.
  - 11: 4bpp {S7..S4}, step 4.
  - The index is zero-extended, or truncated to its low IDX_BITS bits when IDX_BITS is smaller than the format width.
- Cursor logic, updated only on CE_CRTC:
  - SEG <= CURSOR ? 1 : SEG<<1 (CURSOR_SEGS bits; bits shifted out are lost).
  - CUR_Q <= CURSOR&CTRL[7] | SEG[0]&CTRL[6] | (|SEG[CURSOR_SEGS-1:1])&CTRL[5].
  - When CURSOR_SEGS=1, the CTRL[5] term is 0.
- Output stage, registered every PIXELCLK:
  - E = palette[index]. C = E colour, XOR all-ones if (E.flash & CTRL[0]).
  - P = DISEN_Q ? C : 0.
  - RGB <= CUR_Q ? ~P : P.
  - Latency is 1 PIXELCLK from a SHIFT change to RGB.
- Blanking: with DISEN_Q=0, RGB is 0 regardless of the palette, or all-ones while the cursor is active.
- Reset mid-line clears the shift pipeline immediately. The first valid pixel follows the next CE_CRTC load.

Optional Feature:
- Macro: VIDEO_SERIALISER_PAL_READ_EN.
- Defined: adds output PAL_RDATA, width 3*CH_BITS+1, registered palette[PAL_IDX] every PIXELCLK. Reset value is 0, and a read has 1 cycle latency.
- Undefined: no PAL_RDATA port and no read mux.
- Core behaviour is identical either way.

Test Plan:
- Reset release, CTRL=0 -> CE_RAM period 4, CE_PROC period 8, CE_CRTC period 16; first CE_CRTC 16 clocks after release.
- CH_BITS=1. Palette all-ones pattern: entry i = {0, i[2:0]}. CTRL=0x1C (fast CRTC, rate 11), FMT=11, DATA=0x5A, DISEN=1 -> RGB per pixel = 5,2,7,7,7,7,7,7; the byte reloads every 8 clocks.
- FMT=01, CTRL=0x1C, palette[0]=0, palette[1]=7, DATA=0xA5 -> 7,0,7,0,0,7,0,7.
- Flash: palette[3]={1,3'b001}, index 3 shown. CTRL[0]=0 -> RGB=1. Write CTRL[0]=1 -> RGB=6 from the next pixel.
- Cursor: CTRL[7:5]=111, one CURSOR pulse, CURSOR_SEGS=3 -> 4 consecutive CRTC characters output inverted, then normal. With CTRL=0x80 -> only 1 character inverted.
- Assert RESET for 1 clock mid-pixel with DATA=0xFF -> RGB=0 and CE_* low immediately. DIV restarts and the first CE_PROC arrives 8 clocks later.

Source files
------------

// File: rtl/video_serialiser_pal.sv
// Pixel serialiser with palette lookup, flash and cursor overlay in the single PIXELCLK domain.
// Optional palette read-back port PAL_RDATA: define VIDEO_SERIALISER_PAL_READ_EN.
module video_serialiser_pal #(
  parameter int CH_BITS     = 1,
  parameter int IDX_BITS    = 4,
  parameter int CURSOR_SEGS = 3
) (
  input  logic                  PIXELCLK,
  input  logic                  RESET,
  input  logic                  CTRL_WE,
  input  logic [7:0]            CTRL_DATA,
  input  logic                  FMT_WE,
  input  logic [1:0]            FMT_DATA,
  input  logic                  PAL_WE,
  input  logic [IDX_BITS-1:0]   PAL_IDX,
  input  logic [3*CH_BITS:0]    PAL_DATA,
  input  logic [7:0]            DATA,
  input  logic                  DISEN,
  input  logic                  CURSOR,
  output logic                  CE_RAM,
  output logic                  CE_PROC,
  output logic                  CE_CRTC,
  output logic [CH_BITS-1:0]    RED,
  output logic [CH_BITS-1:0]    GREEN,
  output logic [CH_BITS-1:0]    BLUE
`ifdef VIDEO_SERIALISER_PAL_READ_EN
  ,
  output logic [3*CH_BITS:0]    PAL_RDATA
`endif
);

  localparam int CW   = 3 * CH_BITS;
  localparam int PW   = CW + 1;
  localparam int NPAL = 1 << IDX_BITS;

  logic [3:0]             div_q;
  logic [7:0]             ctrl_q;
  logic [1:0]             fmt_q;
  logic [7:0]             shift_q;
  logic [PW-1:0]          pal_q [NPAL];
  logic [CURSOR_SEGS-1:0] seg_q;
  logic                   cur_q;
  logic                   disen_q;
  logic [CW-1:0]          rgb_q;

  logic                   ce_16;
  logic [2:0]             rate_mask;
  logic                   shift_tick;
  logic [7:0]             shift_d;
  logic [3:0]             raw_idx;
  logic [IDX_BITS-1:0]    pix_idx;
  logic [PW-1:0]          pal_entry;
  logic [CW-1:0]          colour;
  logic [CW-1:0]          pix;
  logic [CW-1:0]          rgb_d;
  logic                   ctrl_unused;

  assign ctrl_unused = ctrl_q[1];

  // Clock-enable strobes are pure decodes of the free-running divider.
  assign CE_RAM  = (div_q[1:0] == 2'd3);
  assign CE_PROC = (div_q[2:0] == 3'd7);
  assign ce_16   = (div_q == 4'd15);
  assign CE_CRTC = ctrl_q[4] ? CE_PROC : ce_16;

  always_comb begin
    rate_mask = 3'd7;
    case (ctrl_q[3:2])
      2'b00:   rate_mask = 3'd7;
      2'b01:   rate_mask = 3'd3;
      2'b10:   rate_mask = 3'd1;
      default: rate_mask = 3'd0;
    endcase
  end

  assign shift_tick = ((div_q[2:0] & rate_mask) == rate_mask);

  // Shift step follows the pixel width; vacated bits fill with ones.
  always_comb begin
    shift_d = {shift_q[6:0], 1'b1};
    raw_idx = {shift_q[7], shift_q[5], shift_q[3], shift_q[1]};
    case (fmt_q)
      2'b01: begin
        shift_d = {shift_q[6:0], 1'b1};
        raw_idx = {3'b000, shift_q[7]};
      end
      2'b10: begin
        shift_d = {shift_q[5:0], 2'b11};
        raw_idx = {2'b00, shift_q[7:6]};
      end
      2'b11: begin
        shift_d = {shift_q[3:0], 4'hF};
        raw_idx = shift_q[7:4];
      end
      default: begin
        shift_d = {shift_q[6:0], 1'b1};
        raw_idx = {shift_q[7], shift_q[5], shift_q[3], shift_q[1]};
      end
    endcase
  end

  assign pix_idx   = raw_idx[IDX_BITS-1:0];
  assign pal_entry = pal_q[pix_idx];
  assign colour    = pal_entry[CW-1:0] ^ {CW{pal_entry[CW] & ctrl_q[0]}};
  assign pix       = disen_q ? colour : '0;
  assign rgb_d     = cur_q ? ~pix : pix;

  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) begin
      div_q  <= 4'd0;
      ctrl_q <= 8'd0;
      fmt_q  <= 2'd0;
    end else begin
      div_q <= div_q + 4'd1;
      if (CTRL_WE) ctrl_q <= CTRL_DATA;
      if (FMT_WE)  fmt_q  <= FMT_DATA;
    end
  end

  // Palette reads are combinational from registers, so a same-cycle write is seen next cycle.
  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NPAL; i++) pal_q[i] <= '0;
    end else if (PAL_WE) begin
      pal_q[PAL_IDX] <= PAL_DATA;
    end
  end

  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) begin
      shift_q <= 8'd0;
      disen_q <= 1'b0;
    end else if (CE_CRTC) begin
      shift_q <= DATA;
      disen_q <= DISEN;
    end else if (shift_tick) begin
      shift_q <= shift_d;
    end
  end

  // Cursor trail: SEG[0] is the character after the pulse, upper bits the rest of the trail.
  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) begin
      seg_q <= '0;
      cur_q <= 1'b0;
    end else if (CE_CRTC) begin
      seg_q <= CURSOR ? CURSOR_SEGS'(1) : (seg_q << 1);
      cur_q <= (CURSOR & ctrl_q[7]) | (seg_q[0] & ctrl_q[6]) |
               ((|(seg_q >> 1)) & ctrl_q[5]);
    end
  end

  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign RED   = rgb_q[CH_BITS-1:0];
  assign GREEN = rgb_q[2*CH_BITS-1:CH_BITS];
  assign BLUE  = rgb_q[CW-1:2*CH_BITS];

`ifdef VIDEO_SERIALISER_PAL_READ_EN
  logic [PW-1:0] rdata_q;

  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= pal_q[PAL_IDX];
  end

  assign PAL_RDATA = rdata_q;
`endif

endmodule
